// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic               is_signed, is_div, sign_a, sign_b, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, mul_addend, div_diff, q_fix, r_fix;
  logic [WIDTH:0]     mul_sum, div_part;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Operand decode and per-iteration arithmetic
  always_comb begin
    is_signed  = ~op_q[0];
    is_div     = op_q[1];
    sign_a     = is_signed & a_q[WIDTH-1];
    sign_b     = is_signed & b_q[WIDTH-1];
    b_zero     = (b_q == '0);
    mag_a      = sign_a ? -a_q : a_q;
    mag_b      = sign_b ? -b_q : b_q;
    mul_addend = acc_lo_q[0] ? mag_b : '0;
    mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
    div_part   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge     = (div_part >= {1'b0, mag_b});
    // Remainder stays below the divisor, so the low WIDTH bits hold the difference.
    div_diff   = div_part[WIDTH-1:0] - mag_b;
    prod       = {acc_hi_q, acc_lo_q};
    prod_fix   = (sign_a ^ sign_b) ? -prod : prod;
    q_fix      = (sign_a ^ sign_b) ? -acc_lo_q : acc_lo_q;
    r_fix      = sign_a ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !cancel) state_d = RUN;
      RUN: begin
        if (cancel)              state_d = IDLE;
        else if (cnt_q == LAST)  state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count 0 of RUN loads magnitudes; counts 1..WIDTH each retire one bit.
  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cancel) begin
          if (start) begin
            a_d   = a;
            b_d   = b;
            op_d  = op;
            cnt_d = '0;
          end else begin
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
          end
        end
      end
      RUN: begin
        if (!cancel) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            acc_hi_d = '0;
            acc_lo_d = mag_a;
          end else if (is_div) begin
            acc_hi_d = div_ge ? div_diff : div_part[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
      end
      FIX: begin
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div) begin
            if (b_zero) begin
              hi_d       = a_q;
              lo_d       = '1;
              div_zero_d = 1'b1;
            end else begin
              hi_d = r_fix;
              lo_d = q_fix;
            end
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = ((state_q == RUN) && (cnt_q != '0)) || (state_q == FIX);
    done     = done_q;
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and HI/LO width; legal values are even integers from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, requesting a new operation.
REQ-005 The block SHALL have port op, input, 2, selecting the operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have port a, input, WIDTH, holding the multiplicand or dividend.
REQ-007 The block SHALL have port b, input, WIDTH, holding the multiplier or divisor.
REQ-008 The block SHALL have port cancel, input, 1, the pipeline flush that aborts the operation in flight.
REQ-009 The block SHALL have ports mthi and mtlo, input, 1 each, which write wdata into HI or LO.
REQ-010 The block SHALL have port wdata, input, WIDTH, the data for mthi/mtlo.
REQ-011 The block SHALL have port busy, output, 1, high while an operation is in flight; the hazard logic stalls on it.
REQ-012 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 The block SHALL have port div_zero, output, 1, asserted together with done when a division had b == 0.
REQ-014 The block SHALL have ports hi and lo, output, WIDTH each, which are the registered HI/LO values.

Function
REQ-015 The block SHALL use the states IDLE, RUN and FIX.
- IDLE -> RUN on start.
- RUN -> FIX after exactly WIDTH iterations, one bit per cycle: shift-add for multiply, restoring for divide, on operand magnitudes.
- FIX -> IDLE after one cycle, applying sign correction and committing HI/LO.
REQ-016 Operands and op SHALL be captured on the accepting edge; later changes to a, b and op SHALL have no effect.
REQ-017 Latency SHALL be as follows for start accepted at edge k:
- busy = 1 from edge k+1 through edge k+WIDTH+1;
- hi/lo update at edge k+WIDTH+2;
- done = 1 for exactly the cycle after edge k+WIDTH+2;
- busy = 0 in that same cycle.
REQ-018 Multiply SHALL produce {hi,lo} = the full 2*WIDTH-bit product, interpreted as signed for MULT and unsigned for MULTU.
REQ-019 Divide SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign, with |hi| < |b|.
REQ-020 Signed DIV of most-negative / -1 SHALL give lo = most-negative and hi = 0, with no error flag.
REQ-021 Divide by zero SHALL give hi = a and lo = all ones, with div_zero pulsed together with done.
REQ-022 start, mthi and mtlo SHALL be ignored while busy; no queuing.
REQ-023 In IDLE, start together with mthi/mtlo SHALL mean start wins and the move is ignored.
REQ-024 mthi and mtlo in the same IDLE cycle SHALL write both registers.
REQ-025 cancel while busy SHALL return the block to IDLE at the next edge, with hi/lo unchanged, no done and no div_zero; a new start SHALL be accepted in the following cycle.
REQ-026 cancel in IDLE SHALL suppress start and mthi/mtlo in that cycle.
REQ-027 cancel in the FIX cycle SHALL also abort; the commit is suppressed.
REQ-028 hi and lo SHALL change only on a FIX commit, mthi/mtlo, or reset.

Reset
REQ-029 reset SHALL force the following at the next edge, from any state including mid-operation:
- state = IDLE;
- busy = 0, done = 0, div_zero = 0;
- hi = 0, lo = 0;
- the iteration counter is cleared.
REQ-030 reset SHALL take priority over start, cancel, mthi and mtlo.

Verification (WIDTH=32)
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 34 edges after the accepting edge; busy high for 33 cycles.
REQ-032 MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU a=7, b=0 -> hi=0x00000007, lo=0xFFFFFFFF, div_zero=1 with done; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Start MULT, then cancel 10 cycles later -> busy=0 next cycle; hi/lo hold prior values; no done; an immediate new start completes normally.
REQ-035 In IDLE, mthi wdata=0x12345678 -> hi=0x12345678; mtlo while busy -> lo unchanged.
REQ-036 Assert reset at RUN iteration 20 -> next cycle busy=0, hi=lo=0, no done ever pulses for the aborted operation.
